// File: rtl/pipeline_opcode_tracker_if.sv
// Per-stage opcode interface between instruction fetch, the opcode tracker
// (master/producer side) and the pipeline control decoder (slave side).
interface pipeline_opcode_tracker_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      inst;
  logic             inst_valid;
  logic             br_taken;
  logic [4:0]       opcode_f;
  logic [4:0]       opcode_rr;
  logic [4:0]       opcode_ex;
  logic [4:0]       opcode_wb;
  logic [15:0]      inst_rr;
  logic [15:0]      inst_ex;
  logic [15:0]      inst_wb;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  inst, inst_valid, br_taken,
    output opcode_f, opcode_rr, opcode_ex, opcode_wb,
    output inst_rr, inst_ex, inst_wb,
    output stall, flush, retired, stall_cycles
  );

  modport slave (
    output inst, inst_valid, br_taken,
    input  opcode_f, opcode_rr, opcode_ex, opcode_wb,
    input  inst_rr, inst_ex, inst_wb,
    input  stall, flush, retired, stall_cycles
  );
endinterface

// File: rtl/pipeline_opcode_tracker.sv
// Four-stage (F/RR/EX/WB) instruction word pipeline with bubble insertion on
// fetch gaps and RAW hazards, branch flush, and retire/stall counters.
module pipeline_opcode_tracker #(
  parameter logic [4:0] BUBBLE_OP = 5'b00111,
  parameter int         CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  pipeline_opcode_tracker_if.master bus
);

  localparam logic [15:0] BUBBLE_WORD = {11'b0, BUBBLE_OP};

  logic [15:0]      f_q, rr_q, ex_q, wb_q;
  logic [CNT_W-1:0] retired_q, stall_cnt_q;
  logic             hazard;
  logic             flush_now;

  function automatic logic writes(input logic [4:0] op);
    if (op == BUBBLE_OP) return 1'b0;
    return (!op[3] && !(op[1] && op[0])) || (op[3:0] == 4'b1100);
  endfunction

  function automatic logic [2:0] dest(input logic [15:0] word);
    return word[3] ? 3'd7 : word[7:5];
  endfunction

  function automatic logic reads_rx(input logic [4:0] op);
    return (op[3:0] inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110}) ||
           (op[3] && !op[4]);
  endfunction

  function automatic logic reads_ry(input logic [4:0] op);
    return !op[4] && !op[3] && (op != BUBBLE_OP);
  endfunction

  // No forwarding: any pending write in EX or WB to a source register stalls.
  function automatic logic pending_write(input logic [2:0] src,
                                         input logic [15:0] ex_word,
                                         input logic [15:0] wb_word);
    return (writes(ex_word[4:0]) && (dest(ex_word) == src)) ||
           (writes(wb_word[4:0]) && (dest(wb_word) == src));
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (reads_rx(rr_q[4:0]) && pending_write(rr_q[7:5], ex_q, wb_q))
      hazard = 1'b1;
    if (reads_ry(rr_q[4:0]) && pending_write(rr_q[10:8], ex_q, wb_q))
      hazard = 1'b1;
  end

  assign flush_now = bus.br_taken & ex_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q         <= BUBBLE_WORD;
      rr_q        <= BUBBLE_WORD;
      ex_q        <= BUBBLE_WORD;
      wb_q        <= BUBBLE_WORD;
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (wb_q != BUBBLE_WORD)
        retired_q <= retired_q + CNT_W'(1);
      wb_q <= ex_q;
      // Flush takes precedence over a concurrent hazard stall.
      if (flush_now) begin
        f_q  <= BUBBLE_WORD;
        rr_q <= BUBBLE_WORD;
        ex_q <= BUBBLE_WORD;
      end else if (hazard) begin
        ex_q        <= BUBBLE_WORD;
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end else begin
        f_q  <= bus.inst_valid ? bus.inst : BUBBLE_WORD;
        rr_q <= f_q;
        ex_q <= rr_q;
      end
    end
  end

  assign bus.opcode_f     = f_q[4:0];
  assign bus.opcode_rr    = rr_q[4:0];
  assign bus.opcode_ex    = ex_q[4:0];
  assign bus.opcode_wb    = wb_q[4:0];
  assign bus.inst_rr      = rr_q;
  assign bus.inst_ex      = ex_q;
  assign bus.inst_wb      = wb_q;
  assign bus.stall        = hazard;
  assign bus.flush        = flush_now;
  assign bus.retired      = retired_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_opcode_tracker.sv
// Scoreboard bench: words expected to retire are queued when driven and
// matched against inst_wb as they arrive; stage, hazard and counter checks inline.
module tb_pipeline_opcode_tracker;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;
  logic [15:0] sb_q[$];

  pipeline_opcode_tracker_if #(.CNT_W(16)) bus ();

  pipeline_opcode_tracker #(
    .BUBBLE_OP(5'b00111),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  always @(posedge clk) begin
    #2;
    if (bus.inst_wb !== 16'h0007) begin
      if (sb_q.size() == 0) check_val("wb_unexpected", bus.inst_wb, 16'h0007);
      else check_val("wb_word", bus.inst_wb, sb_q.pop_front());
    end
  end

  logic [15:0] t1 [4];
  logic [15:0] w;
  logic [15:0] r0;
  logic [15:0] sc0;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.inst = '0;
    bus.inst_valid = 1'b0;
    bus.br_taken = 1'b0;
    ticks(2);
    check_val("rst_f", bus.opcode_f, 5'h07);
    check_val("rst_rr", bus.opcode_rr, 5'h07);
    check_val("rst_ex", bus.opcode_ex, 5'h07);
    check_val("rst_wb", bus.opcode_wb, 5'h07);
    check_val("rst_stall", bus.stall, 1'b0);
    check_val("rst_flush", bus.flush, 1'b0);
    check_val("rst_retired", bus.retired, 16'h0);
    check_val("rst_stallcnt", bus.stall_cycles, 16'h0);
    reset = 1'b0;

    // Four independent instructions flowing through.
    t1[0] = 16'h0021; t1[1] = 16'h0342; t1[2] = 16'h0584; t1[3] = 16'h00D0;
    for (int i = 0; i < 4; i++) begin
      w = t1[i];
      bus.inst = w;
      bus.inst_valid = 1'b1;
      sb_q.push_back(w);
      tick();
      check_val("t1_f", bus.opcode_f, w[4:0]);
      check_val("t1_stall", bus.stall, 1'b0);
    end
    check_val("t1_rr", bus.opcode_rr, 5'h04);
    check_val("t1_ex", bus.opcode_ex, 5'h02);
    check_val("t1_wb", bus.opcode_wb, 5'h01);
    bus.inst_valid = 1'b0;
    ticks(4);
    check_val("t1_retired", bus.retired, 16'd4);

    // RAW hazard: add R1 then an op reading R1 as Ry.
    sc0 = bus.stall_cycles;
    bus.inst = 16'h0021; bus.inst_valid = 1'b1; sb_q.push_back(16'h0021); tick();
    bus.inst = 16'h0143; sb_q.push_back(16'h0143); tick();
    check_val("t2_nostall", bus.stall, 1'b0);
    bus.inst_valid = 1'b0;
    tick();
    check_val("t2_stall1", bus.stall, 1'b1);
    check_val("t2_ex_prod", bus.opcode_ex, 5'h01);
    tick();
    check_val("t2_stall2", bus.stall, 1'b1);
    check_val("t2_ex_bub1", bus.opcode_ex, 5'h07);
    check_val("t2_rr_hold", bus.opcode_rr, 5'h03);
    tick();
    check_val("t2_stall_end", bus.stall, 1'b0);
    check_val("t2_ex_bub2", bus.opcode_ex, 5'h07);
    tick();
    check_val("t2_ex_cons", bus.opcode_ex, 5'h03);
    check_val("t2_stallcnt", bus.stall_cycles, sc0 + 16'd2);
    ticks(3);

    // Taken branch flushes the two younger instructions.
    r0 = bus.retired;
    bus.inst = 16'h0019; bus.inst_valid = 1'b1; sb_q.push_back(16'h0019); tick();
    bus.inst = 16'h0030; tick();
    bus.inst = 16'h0050; tick();
    bus.inst = 16'h0070; bus.br_taken = 1'b1; #1;
    check_val("t3_flush", bus.flush, 1'b1);
    tick();
    bus.br_taken = 1'b0; bus.inst_valid = 1'b0; #1;
    check_val("t3_flush_off", bus.flush, 1'b0);
    check_val("t3_f", bus.opcode_f, 5'h07);
    check_val("t3_rr", bus.opcode_rr, 5'h07);
    check_val("t3_ex", bus.opcode_ex, 5'h07);
    check_val("t3_wb", bus.opcode_wb, 5'h19);
    ticks(4);
    check_val("t3_retired", bus.retired, r0 + 16'd1);

    // Branch not taken, then br_taken with a non-branch in EX.
    r0 = bus.retired;
    bus.inst = 16'h0019; bus.inst_valid = 1'b1; sb_q.push_back(16'h0019); tick();
    bus.inst = 16'h0030; sb_q.push_back(16'h0030); tick();
    bus.inst_valid = 1'b0; tick();
    check_val("t3n_noflush", bus.flush, 1'b0);
    tick();
    check_val("t3n_ex_adv", bus.opcode_ex, 5'h10);
    bus.br_taken = 1'b1; #1;
    check_val("t3n_br_ignored", bus.flush, 1'b0);
    tick();
    bus.br_taken = 1'b0;
    ticks(4);
    check_val("t3n_retired", bus.retired, r0 + 16'd2);

    // Flush and stall in the same cycle: call R7 in EX, reader of R7 in RR.
    bus.inst = 16'h000C; bus.inst_valid = 1'b1; sb_q.push_back(16'h000C); tick();
    bus.inst = 16'h0740; tick();
    bus.inst_valid = 1'b0; tick();
    check_val("t4_stall", bus.stall, 1'b1);
    sc0 = bus.stall_cycles;
    bus.br_taken = 1'b1; #1;
    check_val("t4_flush", bus.flush, 1'b1);
    tick();
    bus.br_taken = 1'b0;
    check_val("t4_stallcnt", bus.stall_cycles, sc0);
    check_val("t4_rr", bus.opcode_rr, 5'h07);
    check_val("t4_wb", bus.opcode_wb, 5'h0C);
    ticks(4);

    // Three-cycle fetch gap.
    r0 = bus.retired;
    bus.inst = 16'h0030; bus.inst_valid = 1'b1; sb_q.push_back(16'h0030); tick();
    bus.inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_gap_f", bus.opcode_f, 5'h07);
    end
    bus.inst = 16'h0050; bus.inst_valid = 1'b1; sb_q.push_back(16'h0050); tick();
    check_val("t5_f", bus.opcode_f, 5'h10);
    bus.inst_valid = 1'b0;
    ticks(5);
    check_val("t5_retired", bus.retired, r0 + 16'd2);

    // Reset mid-stream drops in-flight instructions.
    bus.inst = 16'h0030; bus.inst_valid = 1'b1; tick();
    bus.inst = 16'h0050; tick();
    reset = 1'b1; bus.inst_valid = 1'b0; tick();
    reset = 1'b0;
    check_val("t6_f", bus.opcode_f, 5'h07);
    check_val("t6_rr", bus.opcode_rr, 5'h07);
    check_val("t6_retired", bus.retired, 16'h0);
    check_val("t6_stallcnt", bus.stall_cycles, 16'h0);
    ticks(4);
    check_val("t6_retired_after", bus.retired, 16'h0);

    // Retired counter wrap.
    for (int unsigned i = 0; i < 65535; i++) begin
      w = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 5'b10000};
      bus.inst = w; bus.inst_valid = 1'b1; sb_q.push_back(w);
      tick();
    end
    bus.inst_valid = 1'b0;
    ticks(4);
    check_val("t7_retired_max", bus.retired, 16'hFFFF);
    bus.inst = 16'h0030; bus.inst_valid = 1'b1; sb_q.push_back(16'h0030); tick();
    bus.inst_valid = 1'b0;
    ticks(4);
    check_val("t7_retired_wrap", bus.retired, 16'h0);
    check_val("t7_stallcnt", bus.stall_cycles, 16'h0);

    ticks(2);
    check_val("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_opcode_tracker.md
# pipeline_opcode_tracker

Carries each fetched instruction through the four pipeline stages (Fetch, RegFile Read, Execute, Write-Back) and presents the per-stage opcodes that the control decoder turns into stage control signals. It is the producer side of the per-stage opcode interface:

- inserts bubbles on instruction-memory gaps and read-after-write hazards;
- flushes younger stages on a taken branch;
- tracks retired-instruction and stall-cycle counts.

It sits between instruction memory and the pipeline control decoder.

## Interface
- BUBBLE_OP, 5'b00111, opcode injected for a bubble. The decoder yields RegWrite=0, NZ=0 and no memory access for it.
- CNT_W, 16, width of the performance counters.

- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- inst  input  16  fetched instruction word; opcode in [4:0], Rx in [7:5], Ry in [10:8]
- inst_valid  input  1  inst is valid this cycle
- br_taken  input  1  branch in Execute resolved taken this cycle; ignored unless opcode_ex[3]=1
- opcode_f, opcode_rr, opcode_ex, opcode_wb  output  5 each  registered opcode held in each stage
- inst_rr, inst_ex, inst_wb  output  16 each  registered full instruction words for register-field extraction
- stall  output  1  combinational; hold PC and Fetch/RR stages this cycle
- flush  output  1  combinational; equals br_taken & opcode_ex[3]
- retired  output  CNT_W  count of non-bubble instructions leaving Write-Back
- stall_cycles  output  CNT_W  count of cycles with stall=1

## Operation
- Stage registers F→RR→EX→WB each hold a 16-bit word; the opcode output is [4:0] of that word.
- Bubble word = {11'b0, BUBBLE_OP}.
- Write predicate W(op):
  - true when (!op[3] & !(op[1]&op[0])), or when op[3:0]=4'b1100 (call);
  - never true for BUBBLE_OP.
- Destination D(word):
  - R7 when op[3]=1 (call);
  - otherwise Rx.
- Source reads of the RR word:
  - reads Rx when op[3:0] ∈ {0001, 0010, 0011, 0101, 0110}, or when op[3]=1 & op[4]=0 (register branch target);
  - reads Ry when op[4]=0 & op[3]=0 & op≠BUBBLE_OP.
- Hazard: stall=1 when any RR source equals D(EX word) with W(EX op), or equals D(WB word) with W(WB op). There is no forwarding.
- Per-edge priority:
  1. reset.
  2. flush: F←bubble, RR←bubble, EX←bubble, WB←EX. Flush overrides stall.
  3. stall: F and RR hold, EX←bubble, WB←EX.
  4. normal: F←(inst_valid ? inst : bubble), RR←F, EX←RR, WB←EX.
- retired increments when the WB word is not a bubble (it leaves on every non-reset edge).
- stall_cycles increments on every cycle with stall=1 & flush=0.
- Both counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values:
  - all stage words = bubble, so every opcode_* output = 5'b00111;
  - stall=0, flush=0;
  - retired=0, stall_cycles=0.
- Latency: an instruction accepted at edge N appears in opcode_f after edge N, in opcode_rr after N+1, in opcode_ex after N+2 and in opcode_wb after N+3. It is counted in retired after edge N+4.
- inst is sampled only when stall=0 & flush=0. The upstream must hold inst steady while stall=1.
- Maximum stall on a hazard is 2 cycles, ending when the producer leaves WB.
- Simultaneous flush and stall: flush wins. stall_cycles does not increment.
- A branch in EX that is not taken: normal advance, no flush.
- Reset asserted mid-operation: all stages are bubbled on that edge. In-flight instructions are dropped and not counted.

## Test plan
- Reset, then four independent instructions (add 16'h0021 etc., no register overlap) with inst_valid=1 → each opcode appears stage by stage, one per cycle; retired=4 after 8 edges.
- add R1 (writes Rx=1) followed by sub reading R1 as Ry → stall=1 for exactly 2 cycles; EX shows 5'b00111 twice; stall_cycles=2.
- Branch jz (opcode 5'b11001) in EX with br_taken=1 → flush=1 for one cycle; F and RR become bubble; the two younger instructions never reach WB; retired excludes them.
- flush and stall asserted in the same cycle → flush behaviour applies; stall_cycles unchanged.
- inst_valid=0 for 3 cycles within a stream → 3 bubbles propagate; retired counts only valid instructions.
- Preload retired to 16'hFFFF via 65535 retirements (or a forced counter), then one more retirement → retired wraps to 0.
